pio_target_responder: RTL and testbench
=======================================

# pio_target_responder

Endpoint-side PIO target that answers the root-port controller's BAR accesses. Accepts decoded MemWr32/MemRd32/MemWr64/MemRd64 requests from the RX request decoder and stores write data in a BAR-backed DW memory. For every read, it drives one completion request to the completion TLP generator. Out-of-aperture accesses are reported as Unsupported Request (UR).

## Interface
- TCQ, 1, simulation clock-to-Q delay
- BAR_A_64BIT, 0, 1 = 64-bit request types are decoded; 0 = they are UR
- BAR_A_BASE, 32'h1000_0000, aperture base byte address
- BAR_A_SIZE, 1024, aperture size in DW; power of two, 16..4096
- user_clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- user_lnk_up  in  1  link status; low acts as a soft reset of the FSM
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_type  in  3  000 MemRd32, 001 MemWr32, 010 MemRd64, 011 MemWr64; others UR
- req_tag  in  8  requester tag
- req_rid  in  16  requester ID
- req_addr  in  64  byte address
- req_data  in  32  write data (1 DW)
- cpl_start  out  1  one-cycle pulse: completion fields valid
- cpl_type  out  1  0 Cpl (no data), 1 CplD
- cpl_tag  out  8  echoed req_tag
- cpl_rid  out  16  echoed req_rid
- cpl_status  out  3  000 SC, 001 UR
- cpl_lower_addr  out  7  {req_addr[6:2], 2'b00}
- cpl_data  out  32  read data; 0 for Cpl
- cpl_done  in  1  completion TLP fully transmitted
- wr_count, rd_count, ur_count  out  12 each  saturating statistics

## Operation
- FSM states: ST_IDLE, ST_WRITE, ST_READ, ST_CPL, ST_CPL_WAIT.
- req_ready = 1 only in ST_IDLE with user_lnk_up high and reset low.
- Accept: capture type, tag, rid, addr, and data.
- Hit condition: addr >= BAR_A_BASE and addr < BAR_A_BASE + 4*BAR_A_SIZE.
  - 32-bit types additionally require addr[63:32] == 0.
  - 64-bit types require BAR_A_64BIT = 1.
- DW index = (addr − BAR_A_BASE) >> 2, truncated to log2(BAR_A_SIZE) bits.
- Write path: ST_IDLE → ST_WRITE → ST_IDLE.
  - Hit: RAM write in ST_WRITE; wr_count+1.
  - Miss: write dropped; ur_count+1.
  - No completion in either case (posted).
- Read path: ST_IDLE → ST_READ → ST_CPL → ST_CPL_WAIT → ST_IDLE.
  - ST_READ: RAM read issued.
  - ST_CPL: outputs latched; cpl_start=1.
  - Hit: CplD, SC, RAM data; rd_count+1.
  - Miss: Cpl, UR, data 0; ur_count+1.
  - ST_CPL_WAIT: hold on cpl_* until cpl_done, then go to ST_IDLE.
- Unknown req_type: treated as a posted miss; ur_count+1; no completion.
- cpl_done outside ST_CPL_WAIT is ignored.
- Counters saturate at 12'hfff.

## Timing
- Reset values: req_ready 0, cpl_start 0, cpl_type 0, cpl_tag 0, cpl_rid 0, cpl_status 0, cpl_lower_addr 0, cpl_data 0, all counters 0. RAM contents are not reset.
- Write occupancy: 2 cycles (ready low for 1 cycle after accept).
- Read latency: accept edge to cpl_start high = 2 cycles. The RAM has 1-cycle synchronous read.
- cpl_* fields stay stable from cpl_start until the cycle after cpl_done.
- cpl_done in the same cycle as cpl_start is legal: FSM skips ST_CPL_WAIT and returns to ST_IDLE.
- user_lnk_up low or reset in any state: FSM to ST_IDLE next cycle.
  - Any pending completion is abandoned; cpl_start is never raised for it.
  - Counters clear on reset only, not on link down.
- Back-to-back requests: next accept no earlier than 1 cycle after return to ST_IDLE.

## Configuration
- PIO_STATS_EN defined: wr_count, rd_count, and ur_count are implemented as described.
- PIO_STATS_EN undefined: no counter flops; the three outputs are tied to 0.
- FSM and completion behaviour are identical in both builds.

## Structure
- Shared package pio_pkg:
  - tx_type encodings (TX_TYPE_MEMRD32 … TX_TYPE_MEMWR64)
  - RX_TYPE_CPL / RX_TYPE_CPLD
  - CPL_STATUS_SC / CPL_STATUS_UR
  - FSM state constants
- Sub-module pio_bar_ram: single-port, BAR_A_SIZE × 32, synchronous read, write enable, no reset.

## Test plan
- MemWr32 0x1234_5678 to 0x1000_0010, then MemRd32 same address, tag 0x05 → one cpl_start; CplD, tag 0x05, SC, lower_addr 0x10, data 0x1234_5678; wr_count=1, rd_count=1.
- MemRd32 to 0x1000_1000 (just past 1024 DW) → Cpl, status UR, data 0; ur_count=1.
- MemWr32 0xDEAD_BEEF to 0x0FFF_FFFC → no cpl_start; ur_count=1; a following read of 0x1000_0000 returns the prior value.
- req_valid held with Wr then Rd, cpl_done 3 cycles after cpl_start:
  - req_ready pattern: 1,0,1,0,0,0,0,0,1.
  - Same-cycle cpl_done variant: FSM returns to ST_IDLE directly.
- Drop user_lnk_up in ST_CPL_WAIT → next cycle ST_IDLE, req_ready 0 while link is down; no further cpl_start; counters retained.
- Controller-style sweep of 4096 Wr/Rd pairs at BAR_A_BASE + 4·n → n < 1024 return SC with 0x1234_5678; n ≥ 1024 return UR; final wr_count=1024, rd_count=1024, ur_count=4095 (saturated) with PIO_STATS_EN; all 0 without it.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared encodings, FSM states and a saturating-increment helper for the PIO target responder.
package pio_pkg;

    localparam logic [2:0] TX_TYPE_MEMRD32 = 3'b000;
    localparam logic [2:0] TX_TYPE_MEMWR32 = 3'b001;
    localparam logic [2:0] TX_TYPE_MEMRD64 = 3'b010;
    localparam logic [2:0] TX_TYPE_MEMWR64 = 3'b011;

    localparam logic RX_TYPE_CPL  = 1'b0;
    localparam logic RX_TYPE_CPLD = 1'b1;

    localparam logic [2:0] CPL_STATUS_SC = 3'b000;
    localparam logic [2:0] CPL_STATUS_UR = 3'b001;

    localparam int CNT_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_READ     = 3'd2,
        ST_CPL      = 3'd3,
        ST_CPL_WAIT = 3'd4
    } pio_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/pio_bar_ram.sv
// Single-port DW memory backing the BAR aperture; synchronous read, no reset on contents.
module pio_bar_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/pio_target_responder.sv
// Endpoint PIO target: BAR-backed DW memory with read completions and UR reporting.
// Statistics counters are built only when PIO_STATS_EN is defined; otherwise they read 0.
module pio_target_responder
    import pio_pkg::*;
#(
    parameter int          TCQ         = 1,
    parameter bit          BAR_A_64BIT = 1'b0,
    parameter logic [31:0] BAR_A_BASE  = 32'h1000_0000,
    parameter int          BAR_A_SIZE  = 1024
) (
    input  logic        user_clk,
    input  logic        reset,
    input  logic        user_lnk_up,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_type,
    input  logic [7:0]  req_tag,
    input  logic [15:0] req_rid,
    input  logic [63:0] req_addr,
    input  logic [31:0] req_data,
    output logic        cpl_start,
    output logic        cpl_type,
    output logic [7:0]  cpl_tag,
    output logic [15:0] cpl_rid,
    output logic [2:0]  cpl_status,
    output logic [6:0]  cpl_lower_addr,
    output logic [31:0] cpl_data,
    input  logic        cpl_done,
    output logic [11:0] wr_count,
    output logic [11:0] rd_count,
    output logic [11:0] ur_count
);

    localparam int          IDX_W   = $clog2(BAR_A_SIZE);
    localparam logic [63:0] BASE64  = {32'h0, BAR_A_BASE};
    localparam logic [63:0] LIMIT64 = BASE64 + 64'(BAR_A_SIZE) * 64'd4;

    if (TCQ < 0 || BAR_A_SIZE < 16 || BAR_A_SIZE > 4096 ||
        (BAR_A_SIZE & (BAR_A_SIZE - 1)) != 0) begin : g_cfg_check
        $error("pio_target_responder: illegal TCQ or BAR_A_SIZE");
    end

    pio_state_t  state_q, state_d;
    logic [2:0]  type_q;
    logic [7:0]  tag_q;
    logic [15:0] rid_q;
    logic [63:0] addr_q;
    logic [31:0] data_q;
    logic        link_ok, accept, is_read, in_range, hit;
    logic        ram_we, ram_re;
    logic [IDX_W-1:0] ram_addr;
    logic [31:0] ram_rdata;

    assign link_ok   = user_lnk_up && !reset;
    assign req_ready = (state_q == ST_IDLE) && link_ok;
    assign accept    = req_valid && req_ready;
    assign is_read   = (req_type == TX_TYPE_MEMRD32) || (req_type == TX_TYPE_MEMRD64);
    assign in_range  = (addr_q >= BASE64) && (addr_q < LIMIT64);

    always_comb begin
        hit = 1'b0;
        case (type_q)
            TX_TYPE_MEMRD32, TX_TYPE_MEMWR32: hit = in_range && (addr_q[63:32] == 32'h0);
            TX_TYPE_MEMRD64, TX_TYPE_MEMWR64: hit = BAR_A_64BIT && in_range;
            default:                          hit = 1'b0;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Link loss behaves like a soft reset: any in-flight request is simply abandoned.
    always_comb begin
        state_d = state_q;
        if (!user_lnk_up) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     if (accept) state_d = is_read ? ST_READ : ST_WRITE;
                ST_WRITE:    state_d = ST_IDLE;
                ST_READ:     state_d = ST_CPL;
                ST_CPL:      state_d = cpl_done ? ST_IDLE : ST_CPL_WAIT;
                ST_CPL_WAIT: if (cpl_done) state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        if (accept) begin
            type_q <= req_type;
            tag_q  <= req_tag;
            rid_q  <= req_rid;
            addr_q <= req_addr;
            data_q <= req_data;
        end
    end

    assign ram_addr = IDX_W'((addr_q - BASE64) >> 2);
    assign ram_we   = (state_q == ST_WRITE) && hit && link_ok;
    assign ram_re   = (state_q == ST_READ) && link_ok;

    pio_bar_ram #(
        .DEPTH (BAR_A_SIZE),
        .AW    (IDX_W)
    ) u_bar_ram (
        .clk   (user_clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    // Header fields load on the way into ST_CPL and hold until the next read.
    always_ff @(posedge user_clk) begin
        if (reset) begin
            cpl_type       <= RX_TYPE_CPL;
            cpl_tag        <= 8'h0;
            cpl_rid        <= 16'h0;
            cpl_status     <= CPL_STATUS_SC;
            cpl_lower_addr <= 7'h0;
        end else if ((state_q == ST_READ) && link_ok) begin
            cpl_type       <= hit ? RX_TYPE_CPLD : RX_TYPE_CPL;
            cpl_tag        <= tag_q;
            cpl_rid        <= rid_q;
            cpl_status     <= hit ? CPL_STATUS_SC : CPL_STATUS_UR;
            cpl_lower_addr <= {addr_q[6:2], 2'b00};
        end
    end

    // RAM output only moves on a read, so it is stable for the whole completion.
    assign cpl_data  = (cpl_type == RX_TYPE_CPLD) ? ram_rdata : 32'h0;
    assign cpl_start = (state_q == ST_CPL) && link_ok;

`ifdef PIO_STATS_EN
    always_ff @(posedge user_clk) begin
        if (reset) begin
            wr_count <= '0;
            rd_count <= '0;
            ur_count <= '0;
        end else if (user_lnk_up) begin
            if (state_q == ST_WRITE) begin
                if (hit) wr_count <= sat_inc(wr_count);
                else     ur_count <= sat_inc(ur_count);
            end else if (state_q == ST_CPL) begin
                if (hit) rd_count <= sat_inc(rd_count);
                else     ur_count <= sat_inc(ur_count);
            end
        end
    end
`else
    assign wr_count = '0;
    assign rd_count = '0;
    assign ur_count = '0;
`endif

endmodule

// File: tb/tb_pio_target_responder.sv
// Directed self-checking bench for pio_target_responder (expects counters only with PIO_STATS_EN).
module tb_pio_target_responder;
    import pio_pkg::*;

`ifdef PIO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        user_clk = 1'b0;
    logic        reset, user_lnk_up, req_valid, req_ready;
    logic [2:0]  req_type;
    logic [7:0]  req_tag;
    logic [15:0] req_rid;
    logic [63:0] req_addr;
    logic [31:0] req_data;
    logic        cpl_start, cpl_type, cpl_done;
    logic [7:0]  cpl_tag;
    logic [15:0] cpl_rid;
    logic [2:0]  cpl_status;
    logic [6:0]  cpl_lower_addr;
    logic [31:0] cpl_data;
    logic [11:0] wr_count, rd_count, ur_count;

    int vecCount = 0;
    int errCount = 0;
    int cplCount = 0;

    bit          gotCpl;
    int          gotLat;
    logic        gotType;
    logic [2:0]  gotStatus;
    logic [7:0]  gotTag;
    logic [15:0] gotRid;
    logic [6:0]  gotLow;
    logic [31:0] gotData;

    always #5 user_clk = ~user_clk;

    pio_target_responder #(
        .TCQ         (1),
        .BAR_A_64BIT (1'b0),
        .BAR_A_BASE  (32'h1000_0000),
        .BAR_A_SIZE  (1024)
    ) dut (
        .user_clk       (user_clk),
        .reset          (reset),
        .user_lnk_up    (user_lnk_up),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_type       (req_type),
        .req_tag        (req_tag),
        .req_rid        (req_rid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .cpl_start      (cpl_start),
        .cpl_type       (cpl_type),
        .cpl_tag        (cpl_tag),
        .cpl_rid        (cpl_rid),
        .cpl_status     (cpl_status),
        .cpl_lower_addr (cpl_lower_addr),
        .cpl_data       (cpl_data),
        .cpl_done       (cpl_done),
        .wr_count       (wr_count),
        .rd_count       (rd_count),
        .ur_count       (ur_count)
    );

    always @(negedge user_clk) begin
        if (cpl_start) cplCount++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one request and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input logic [2:0] t, input logic [63:0] a, input logic [31:0] d,
                                 input logic [7:0] tg, input logic [15:0] r);
        bit accepted = 1'b0;
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = a;
        req_data  = d;
        req_tag   = tg;
        req_rid   = r;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge user_clk);
            if (req_ready) accepted = 1'b1;
            @(posedge user_clk);
            #1;
        end
        req_valid = 1'b0;
        if (!accepted) checkOutput("accept timeout", 64'd0, 64'd1);
    endtask

    task automatic waitCpl(input bit doneNow);
        gotCpl = 1'b0;
        gotLat = 0;
        for (int i = 0; i < 10 && !gotCpl; i++) begin
            @(negedge user_clk);
            if (cpl_start) begin
                gotCpl    = 1'b1;
                gotLat    = i + 1;
                gotType   = cpl_type;
                gotStatus = cpl_status;
                gotTag    = cpl_tag;
                gotRid    = cpl_rid;
                gotLow    = cpl_lower_addr;
                gotData   = cpl_data;
            end
        end
        if (!gotCpl) begin
            checkOutput("cpl_start timeout", 64'd0, 64'd1);
        end else begin
            if (doneNow) cpl_done = 1'b1;
            @(posedge user_clk);
            #1;
            cpl_done = 1'b0;
        end
    endtask

    task automatic doRead(input logic [2:0] t, input logic [63:0] a, input logic [7:0] tg,
                          input logic [15:0] r);
        applyStimulus(t, a, 32'h0, tg, r);
        waitCpl(1'b1);
    endtask

    task automatic checkCounters(input string pfx, input int wr, input int rd, input int ur);
        checkOutput({pfx, " wr_count"}, wr_count, STATS ? 64'(wr) : 64'd0);
        checkOutput({pfx, " rd_count"}, rd_count, STATS ? 64'(rd) : 64'd0);
        checkOutput({pfx, " ur_count"}, ur_count, STATS ? 64'(ur) : 64'd0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (3) @(posedge user_clk);
        #1;
        reset = 1'b0;
        @(posedge user_clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0;
        logic [8:0]  expReady;
        logic [8:0]  expStart;
        logic [63:0] a;
        logic [63:0] exp;

        reset = 1'b1;  user_lnk_up = 1'b1;  req_valid = 1'b0;  cpl_done = 1'b0;
        req_type = 3'b0;  req_tag = 8'h0;  req_rid = 16'h0;  req_addr = 64'h0;  req_data = 32'h0;
        $display("[TB] start");

        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        checkOutput("reset req_ready", req_ready, 0);
        checkOutput("reset cpl_start", cpl_start, 0);
        checkOutput("reset cpl fields", {cpl_type, cpl_tag, cpl_rid, cpl_status, cpl_lower_addr}, 0);
        checkOutput("reset cpl_data", cpl_data, 0);
        checkCounters("reset", 0, 0, 0);
        @(posedge user_clk);
        #1;
        reset = 1'b0;
        @(negedge user_clk);
        checkOutput("ready after reset", req_ready, 1);
        @(posedge user_clk);
        #1;

        // Basic write then read-back.
        applyStimulus(TX_TYPE_MEMWR32, 64'h1000_0010, 32'h1234_5678, 8'h00, 16'h0000);
        doRead(TX_TYPE_MEMRD32, 64'h1000_0010, 8'h05, 16'hABCD);
        checkOutput("rd latency", gotLat, 2);
        checkOutput("rd type", gotType, 1);
        checkOutput("rd tag", gotTag, 8'h05);
        checkOutput("rd rid", gotRid, 16'hABCD);
        checkOutput("rd status", gotStatus, 3'b000);
        checkOutput("rd lower_addr", gotLow, 7'h10);
        checkOutput("rd data", gotData, 32'h1234_5678);
        checkCounters("basic", 1, 1, 0);

        // Read one DW past the aperture.
        doRead(TX_TYPE_MEMRD32, 64'h1000_1000, 8'h06, 16'h0001);
        checkOutput("oob rd type/status/data", {gotType, gotStatus, gotData}, {1'b0, 3'b001, 32'h0});
        checkOutput("oob rd lower_addr", gotLow, 7'h00);
        checkCounters("oob rd", 1, 1, 1);

        // Write below the aperture must be dropped and not alias into the RAM.
        applyStimulus(TX_TYPE_MEMWR32, 64'h1000_0000, 32'hCAFE_F00D, 8'h00, 16'h0);
        applyStimulus(TX_TYPE_MEMWR32, 64'h1000_0FFC, 32'hA5A5_0FFC, 8'h00, 16'h0);
        c0 = cplCount;
        applyStimulus(TX_TYPE_MEMWR32, 64'h0FFF_FFFC, 32'hDEAD_BEEF, 8'h00, 16'h0);
        repeat (3) @(posedge user_clk);
        #1;
        checkOutput("below-base wr no cpl", cplCount, c0);
        checkCounters("below-base wr", 3, 1, 2);
        doRead(TX_TYPE_MEMRD32, 64'h1000_0000, 8'h07, 16'h0002);
        checkOutput("base rd data", {gotType, gotStatus, gotData}, {1'b1, 3'b000, 32'hCAFE_F00D});
        doRead(TX_TYPE_MEMRD32, 64'h1000_0FFC, 8'h08, 16'h0003);
        checkOutput("last DW rd data", {gotType, gotStatus, gotData}, {1'b1, 3'b000, 32'hA5A5_0FFC});
        checkOutput("last DW lower_addr", gotLow, 7'h7C);

        // 64-bit types are UR in this build; high address bits and unknown types miss too.
        doRead(TX_TYPE_MEMRD64, 64'h1000_0010, 8'h09, 16'h0004);
        checkOutput("rd64 type/status/data", {gotType, gotStatus, gotData}, {1'b0, 3'b001, 32'h0});
        c0 = cplCount;
        applyStimulus(TX_TYPE_MEMWR32, 64'h1_1000_0010, 32'hFFFF_FFFF, 8'h00, 16'h0);
        applyStimulus(3'b100, 64'h1000_0010, 32'hEEEE_EEEE, 8'h00, 16'h0);
        applyStimulus(TX_TYPE_MEMWR64, 64'h1000_0010, 32'h7777_7777, 8'h00, 16'h0);
        repeat (3) @(posedge user_clk);
        #1;
        checkOutput("posted misses no cpl", cplCount, c0);
        doRead(TX_TYPE_MEMRD32, 64'h1000_0010, 8'h0A, 16'h0005);
        checkOutput("data kept after misses", gotData, 32'h1234_5678);
        checkCounters("misses", 3, 4, 6);

        // req_valid held across a write then a read; done 3 cycles after start.
        expReady = 9'b1_0000_0101;
        expStart = 9'b0_0001_0000;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin
                    req_valid = 1'b1;  req_type = TX_TYPE_MEMWR32;
                    req_addr = 64'h1000_0020;  req_data = 32'h0BAD_F00D;
                end
                1: begin req_type = TX_TYPE_MEMRD32;  req_tag = 8'h21; end
                3: req_valid = 1'b0;
                7: cpl_done = 1'b1;
                8: cpl_done = 1'b0;
                default: ;
            endcase
            @(negedge user_clk);
            checkOutput($sformatf("ready pattern cycle %0d", i), req_ready, expReady[i]);
            checkOutput($sformatf("start pattern cycle %0d", i), cpl_start, expStart[i]);
            if (i == 4) checkOutput("pattern cpl data", cpl_data, 32'h0BAD_F00D);
            if (i == 6) checkOutput("pattern held fields", {cpl_type, cpl_tag, cpl_status, cpl_data},
                                    {1'b1, 8'h21, 3'b000, 32'h0BAD_F00D});
            @(posedge user_clk);
            #1;
        end
        checkCounters("pattern", 4, 5, 6);

        // Done in the same cycle as start returns straight to idle.
        doRead(TX_TYPE_MEMRD32, 64'h1000_0020, 8'h22, 16'h0006);
        @(negedge user_clk);
        checkOutput("same-cycle done ready", req_ready, 1);
        @(posedge user_clk);
        #1;

        // Link drop while waiting for cpl_done.
        applyStimulus(TX_TYPE_MEMRD32, 64'h1000_0020, 32'h0, 8'h33, 16'h0007);
        waitCpl(1'b0);
        c0 = cplCount;
        user_lnk_up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge user_clk);
            checkOutput($sformatf("link down ready %0d", i), req_ready, 0);
            @(posedge user_clk);
            #1;
        end
        user_lnk_up = 1'b1;
        @(negedge user_clk);
        checkOutput("link back ready", req_ready, 1);
        @(posedge user_clk);
        #1;
        checkOutput("link drop no cpl", cplCount, c0);

        // Link drop during the RAM read abandons the completion entirely.
        applyStimulus(TX_TYPE_MEMRD32, 64'h1000_0020, 32'h0, 8'h34, 16'h0008);
        user_lnk_up = 1'b0;
        @(posedge user_clk);
        #1;
        user_lnk_up = 1'b1;
        cpl_done = 1'b1;
        @(posedge user_clk);
        #1;
        cpl_done = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
        checkOutput("abandoned read no cpl", cplCount, c0);
        checkCounters("link drop", 4, 7, 6);

        // Controller-style sweep across and beyond the aperture.
        doReset();
        checkCounters("sweep start", 0, 0, 0);
        for (int n = 0; n < 4096; n++) begin
            a = 64'h1000_0000 + 64'(n) * 64'd4;
            applyStimulus(TX_TYPE_MEMWR32, a, 32'h1234_5678, 8'h00, 16'h0);
            applyStimulus(TX_TYPE_MEMRD32, a, 32'h0, n[7:0], 16'h0100);
            waitCpl(1'b1);
            exp = (n < 1024) ? {20'h0, n[7:0], 1'b1, 3'b000, 32'h1234_5678}
                             : {20'h0, n[7:0], 1'b0, 3'b001, 32'h0};
            checkOutput($sformatf("sweep n=%0d", n), {20'h0, gotTag, gotType, gotStatus, gotData}, exp);
        end
        checkCounters("sweep end", 1024, 1024, 4095);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
